mem_bus_interconnect: RTL and testbench

// - Parametrised successor to the single-CPU/single-progmem hookup: routes the CPU native bus
//   (addr/wdata/wstrb/rstrb/rdata) to N_SLAVES memory-mapped slaves (RAM, ROM, UART, timer, ...).
// - Adds a wait-state handshake (m_busy), variable slave latency, decode-error and timeout responses.
// - Sits in the SoC top between cpu and all bus slaves; one outstanding transaction at a time.

---
 rtl/mem_bus_interconnect_pkg.sv | 23 ++
 rtl/mem_bus_interconnect_if.sv | 28 ++
 rtl/mem_bus_interconnect_decoder.sv | 23 ++
 rtl/mem_bus_interconnect.sv | 204 ++++++++++++++++++++
 tb/tb_mem_bus_interconnect.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_interconnect_pkg.sv
// rtl/mem_bus_interconnect_pkg.sv - shared types and helpers for the memory bus interconnect
// Purpose: FSM state type, default error read data and the select-width helper
//          used by the interconnect, its decoder and its bus interface users.
// Ports:   none (package)
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // ceil(log2(n)) with a floor of 1, so a single-slave build still has a select bit
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_interconnect_if.sv
// rtl/mem_bus_interconnect_if.sv - CPU native bus interface of the interconnect
// Purpose: bundles the CPU-side request/response signals.
// Ports:   master = CPU view (drives addr/wdata/wstrb/rstrb, receives rdata/busy/err)
//          slave  = interconnect view (the reverse)
interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_rstrb;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_busy;
  logic                m_err;

  modport master (
    output m_addr, m_wdata, m_wstrb, m_rstrb,
    input  m_rdata, m_busy, m_err
  );

  modport slave (
    input  m_addr, m_wdata, m_wstrb, m_rstrb,
    output m_rdata, m_busy, m_err
  );

endinterface

// File: rtl/mem_bus_interconnect_decoder.sv
// rtl/mem_bus_interconnect_decoder.sv - combinational region decoder (bus_addr_decoder)
// Purpose: turns the address bits above the region offset into a slave index and a
//          valid flag.
// Ports:   addr_hi in  HI_W   address bits [ADDR_W-1:REGION_BITS]
//          index   out SEL_W  slave index (low SEL_W bits of addr_hi)
//          valid   out 1      region number is below N_SLAVES
module bus_addr_decoder #(
  parameter int N_SLAVES = 4,
  parameter int HI_W     = 8,
  parameter int SEL_W    = 2
) (
  input  logic [HI_W-1:0]  addr_hi,
  output logic [SEL_W-1:0] index,
  output logic             valid
);

  assign index = addr_hi[SEL_W-1:0];

  // The whole upper field is compared, not just the select bits, so regions
  // beyond the last slave never alias onto a real slave.
  assign valid = ({1'b0, addr_hi} < (HI_W+1)'(N_SLAVES));

endmodule

// File: rtl/mem_bus_interconnect.sv
// rtl/mem_bus_interconnect.sv - single-outstanding CPU bus to N memory-mapped slaves
// Purpose: accepts one CPU request at a time, strobes the decoded slave for one
//          cycle, waits for its ready pulse, and answers with registered read data,
//          a decode-error or a timeout response. Optional statistics counters are
//          built when BUS_STATS_EN is defined.
// Ports:   clk, rst            clock, asynchronous active-high reset
//          cpu (mem_bus_if)    CPU request/response (m_*)
//          s_addr, s_wdata     broadcast address/write data captured at accept
//          s_wstrb, s_rstrb    per-slave write/read strobes, one-cycle pulses
//          s_rdata, s_ready    per-slave read data and completion pulse
//          stat_txn, stat_tmo  completed transaction / timeout counts
module mem_bus_interconnect
  import mem_bus_pkg::*;
#(
  parameter int N_SLAVES    = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 24,
  parameter int TIMEOUT_CYC = 16,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_bus_if.slave                     cpu,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb,
  output logic [N_SLAVES-1:0]          s_rstrb,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_ready,
  output logic [31:0]                  stat_txn,
  output logic [15:0]                  stat_tmo
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = sel_width(N_SLAVES);
  localparam int HI_W   = ADDR_W - REGION_BITS;
  localparam int TMO_W  = sel_width(TIMEOUT_CYC);

  bus_state_e state_q, state_d;

  logic [SEL_W-1:0]    dec_index, sel_q;
  logic                dec_valid, sel_valid_q, is_write_q, early_q;
  logic [DATA_W-1:0]   hold_q, rdata_sel, rdata_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic                busy_q, err_q;
  logic [N_SLAVES-1:0] dec_oh, sel_oh;
  logic                req, is_write_req, ready_hit;
  logic                accept, done_ok, dec_err, timeout;

  assign is_write_req = |cpu.m_wstrb;
  assign req          = cpu.m_rstrb | is_write_req;

  bus_addr_decoder #(
    .N_SLAVES (N_SLAVES),
    .HI_W     (HI_W),
    .SEL_W    (SEL_W)
  ) u_decoder (
    .addr_hi (cpu.m_addr[ADDR_W-1:REGION_BITS]),
    .index   (dec_index),
    .valid   (dec_valid)
  );

  // One-hot forms of the live decode and the captured selection; the captured
  // one also masks s_ready and steers the read-data mux.
  always_comb begin
    dec_oh    = '0;
    sel_oh    = '0;
    rdata_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      dec_oh[i] = dec_valid && (dec_index == SEL_W'(i));
      sel_oh[i] = sel_valid_q && (sel_q == SEL_W'(i));
      if (sel_oh[i]) rdata_sel = s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign ready_hit = |(s_ready & sel_oh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
    dec_err = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!sel_valid_q) begin
          dec_err = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A ready seen during REQ completes here, one cycle later, like a
        // ready in the first WAIT cycle. Ready beats timeout on the same edge.
        if (early_q || ready_hit) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
      s_rstrb     <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      is_write_q  <= 1'b0;
      early_q     <= 1'b0;
      hold_q      <= '0;
      rdata_q     <= '0;
      tmo_cnt_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s_wstrb <= '0;
      s_rstrb <= '0;
      err_q   <= 1'b0;

      if (accept) begin
        s_addr      <= cpu.m_addr;
        s_wdata     <= cpu.m_wdata;
        sel_q       <= dec_index;
        sel_valid_q <= dec_valid;
        is_write_q  <= is_write_req;
        early_q     <= 1'b0;
        tmo_cnt_q   <= '0;
        busy_q      <= 1'b1;
        // Write wins when both strobes are set; dec_oh is zero on a decode miss.
        if (is_write_req) begin
          for (int i = 0; i < N_SLAVES; i++)
            s_wstrb[i*STRB_W +: STRB_W] <= dec_oh[i] ? cpu.m_wstrb : '0;
        end else begin
          s_rstrb <= dec_oh;
        end
      end

      if (state_q == REQ) begin
        early_q <= ready_hit;
        hold_q  <= rdata_sel;
      end

      if (state_q == WAIT && !done_ok && !timeout)
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

      if (done_ok) begin
        busy_q <= 1'b0;
        if (!is_write_q) rdata_q <= early_q ? hold_q : rdata_sel;
      end

      if (dec_err || timeout) begin
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
        rdata_q <= ERR_RDATA;
      end
    end
  end

  assign cpu.m_rdata = rdata_q;
  assign cpu.m_busy  = busy_q;
  assign cpu.m_err   = err_q;

`ifdef BUS_STATS_EN
  logic [31:0] txn_q;
  logic [15:0] tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q <= '0;
      tmo_q <= '0;
    end else begin
      if (done_ok || dec_err || timeout) txn_q <= txn_q + 32'd1;
      if (timeout && tmo_q != 16'hFFFF)  tmo_q <= tmo_q + 16'd1;
    end
  end

  assign stat_txn = txn_q;
  assign stat_tmo = tmo_q;
`else
  assign stat_txn = '0;
  assign stat_tmo = '0;
`endif

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// tb/tb_mem_bus_interconnect.sv - self-checking bench for mem_bus_interconnect
module tb_mem_bus_interconnect;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_rstrb;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ready;
  logic [31:0]     stat_txn;
  logic [15:0]     stat_tmo;

  mem_bus_interconnect #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .REGION_BITS(24), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cpu(bus),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .stat_txn(stat_txn), .stat_tmo(stat_tmo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: last CPU-visible read data and completion counts since reset
  logic [31:0] model_rdata = 32'h0;
  int model_txn = 0;
  int model_tmo = 0;

  // d = cycle after accept in which the target slave pulses ready (1 = REQ cycle).
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic rstrb, input int d,
                         input logic [31:0] data, input bit noisy);
    int region, idx, exp_busy, c, strobe_cycles;
    bit valid, is_wr, exp_err, err_early, tmo_case;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_rs, tgt, noise;
    logic [15:0] exp_ws;

    region = int'(addr >> 24);
    valid  = region < N;
    idx    = valid ? region : 0;
    is_wr  = (wstrb != 4'b0);
    tmo_case = 1'b0;
    if (!valid) begin
      exp_busy = 1; exp_err = 1'b1; exp_rdata = ERR;
    end else if (d <= TMO + 1) begin
      exp_busy = (d < 2) ? 2 : d; exp_err = 1'b0;
      exp_rdata = is_wr ? model_rdata : data;
    end else begin
      exp_busy = TMO + 1; exp_err = 1'b1; exp_rdata = ERR; tmo_case = 1'b1;
    end
    tgt    = valid ? 4'(1 << idx) : 4'b0;
    exp_rs = (valid && !is_wr) ? tgt : 4'b0;
    exp_ws = (valid && is_wr) ? (16'(wstrb) << (idx * 4)) : 16'h0;

    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_wstrb = wstrb;
    bus.m_rstrb = rstrb;
    s_ready     = '0;
    for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = $urandom;
    s_rdata[idx*DW +: DW] = data;

    @(posedge clk); #1;
    if (!noisy) begin bus.m_wstrb = '0; bus.m_rstrb = 1'b0; end

    n_checks++;
    if (s_addr !== addr || s_wdata !== wdata)
      $display("FAIL %s bcast addr/wdata got %h/%h want %h/%h", name, s_addr, s_wdata, addr, wdata);
    else n_pass++;
    n_checks++;
    if (s_rstrb !== exp_rs || s_wstrb !== exp_ws)
      $display("FAIL %s strobes got r=%b w=%h want r=%b w=%h", name, s_rstrb, s_wstrb, exp_rs, exp_ws);
    else n_pass++;

    c = 1; strobe_cycles = 0; err_early = 1'b0;
    while (bus.m_busy === 1'b1 && c < 40) begin
      if (s_rstrb !== 4'b0 || s_wstrb !== 16'h0) strobe_cycles++;
      if (bus.m_err !== 1'b0) err_early = 1'b1;
      noise   = 4'($urandom) & ~tgt;
      s_ready = noise | ((c == d) ? tgt : 4'b0);
      if (noisy) begin bus.m_rstrb = 1'($urandom); bus.m_wstrb = 4'($urandom); end
      @(posedge clk); #1;
      c++;
    end
    bus.m_rstrb = 1'b0; bus.m_wstrb = '0; s_ready = '0;

    n_checks++;
    if (c - 1 != exp_busy)
      $display("FAIL %s busy_cycles got %0d want %0d", name, c - 1, exp_busy);
    else n_pass++;
    n_checks++;
    if (strobe_cycles != (valid ? 1 : 0) || err_early)
      $display("FAIL %s strobe_cycles/err_early got %0d/%0d want %0d/0", name, strobe_cycles, err_early, valid ? 1 : 0);
    else n_pass++;
    n_checks++;
    if (bus.m_rdata !== exp_rdata || bus.m_err !== exp_err)
      $display("FAIL %s response got rdata=%h err=%b want rdata=%h err=%b", name, bus.m_rdata, bus.m_err, exp_rdata, exp_err);
    else n_pass++;

    // Late ready from every slave must be ignored once back in IDLE
    s_ready = '1;
    @(posedge clk); #1;
    s_ready = '0;
    n_checks++;
    if (bus.m_busy !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rdata !== exp_rdata ||
        s_rstrb !== 4'b0 || s_wstrb !== 16'h0)
      $display("FAIL %s after_done got busy=%b err=%b rdata=%h want 0/0/%h", name, bus.m_busy, bus.m_err, bus.m_rdata, exp_rdata);
    else n_pass++;

    model_rdata = exp_rdata;
    model_txn++;
    if (tmo_case) model_tmo++;
  endtask

  task automatic test_reset();
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_rstrb = 1'b0;
    s_rdata = '0; s_ready = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.m_busy !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0)
      $display("FAIL reset cpu_side got busy=%b err=%b rdata=%h want 0/0/0", bus.m_busy, bus.m_err, bus.m_rdata);
    else n_pass++;
    n_checks++;
    if (s_rstrb !== 4'b0 || s_wstrb !== 16'h0 || s_addr !== 32'h0 || s_wdata !== 32'h0)
      $display("FAIL reset slave_side got r=%b w=%h a=%h d=%h want zeros", s_rstrb, s_wstrb, s_addr, s_wdata);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (stat_txn !== 32'h0 || stat_tmo !== 16'h0 || bus.m_busy !== 1'b0)
      $display("FAIL reset stats/idle got txn=%0d tmo=%0d busy=%b want 0/0/0", stat_txn, stat_tmo, bus.m_busy);
    else n_pass++;
    model_rdata = 32'h0; model_txn = 0; model_tmo = 0;
  endtask

  task automatic test_read_zero_wait();
    run_txn("read_zero_wait", 32'h0100_0004, 32'h0, 4'b0000, 1'b1, 1, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_write_wait();
    run_txn("write_wait5", 32'h0200_0000, 32'hA5A5_0F0F, 4'b0011, 1'b0, 7, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_decode_error();
    run_txn("decode_error", 32'h0500_0000, 32'h0, 4'b0000, 1'b1, 1, 32'h0BAD_0BAD, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 32'h0000_0040, 32'h0, 4'b0000, 1'b1, 100, 32'h7777_7777, 1'b0);
    run_txn("ready_last_wait", 32'h0300_0008, 32'h0, 4'b0000, 1'b1, TMO + 1, 32'h0F1E_2D3C, 1'b0);
  endtask

  task automatic test_both_strobes();
    run_txn("both_strobes", 32'h0100_0010, 32'hCAFE_F00D, 4'b1000, 1'b1, 3, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_reset_mid_txn();
    bus.m_addr = 32'h0000_0010; bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_rstrb = 1'b1;
    s_ready = '0;
    @(posedge clk); #1;
    bus.m_rstrb = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.m_busy !== 1'b1)
      $display("FAIL reset_mid busy_before got %b want 1", bus.m_busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.m_busy !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0 ||
        s_rstrb !== 4'b0 || s_wstrb !== 16'h0 || s_addr !== 32'h0)
      $display("FAIL reset_mid async got busy=%b err=%b rdata=%h addr=%h want zeros", bus.m_busy, bus.m_err, bus.m_rdata, s_addr);
    else n_pass++;
    #1 rst = 1'b0;
    s_ready = '1;
    @(posedge clk); #1;
    s_ready = '0;
    n_checks++;
    if (bus.m_busy !== 1'b0 || bus.m_err !== 1'b0)
      $display("FAIL reset_mid idle_after got busy=%b err=%b want 0/0", bus.m_busy, bus.m_err);
    else n_pass++;
    model_rdata = 32'h0; model_txn = 0; model_tmo = 0;
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_read0", 32'h0000_0100, 32'h0, 4'b0000, 1'b1, 2, 32'h0000_BEEF, 1'b0);
    run_txn("b2b_write3", 32'h0300_0004, 32'h1357_9BDF, 4'b1111, 1'b0, 1, 32'h2468_ACE0, 1'b1);
    run_txn("b2b_read2_noisy", 32'h0200_0020, 32'h0, 4'b0000, 1'b1, 4, 32'hFACE_B00C, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic        rstrb;
    for (int k = 0; k < 30; k++) begin
      addr  = {8'($urandom_range(0, 5)), 24'($urandom)};
      wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
      rstrb = (wstrb == 4'b0) ? 1'b1 : 1'($urandom);
      run_txn($sformatf("random_%0d", k), addr, $urandom, wstrb, rstrb,
              $urandom_range(1, 19), $urandom, 1'($urandom));
    end
  endtask

  task automatic test_stats();
`ifdef BUS_STATS_EN
    n_checks++;
    if (stat_txn !== 32'(model_txn) || stat_tmo !== 16'(model_tmo))
      $display("FAIL stats got txn=%0d tmo=%0d want %0d/%0d", stat_txn, stat_tmo, model_txn, model_tmo);
    else n_pass++;
`else
    n_checks++;
    if (stat_txn !== 32'h0 || stat_tmo !== 16'h0)
      $display("FAIL stats_disabled got txn=%0d tmo=%0d want 0/0", stat_txn, stat_tmo);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_reset_mid_txn();
    test_read_zero_wait();
    test_write_wait();
    test_decode_error();
    test_timeout();
    test_both_strobes();
    test_back_to_back();
    test_stats();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
